// File: rtl/imm_gen.sv
// RV32I immediate generator for the flintRV decode stage.
// Decodes the immediate format from the opcode and registers the sign-extended result.
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [XLEN-1:0] i_instr,
    output logic [XLEN-1:0] o_imm
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    imm_fmt_e        imm_fmt;
    logic [6:0]      opcode;
    logic            sign_bit;
    logic [XLEN-1:0] imm_next;

    assign opcode   = i_instr[6:0];
    assign sign_bit = i_instr[31];

    // Only the opcode picks the format; funct3/funct7 never participate.
    always_comb begin
        imm_fmt = FMT_NONE;
        case (opcode)
            OP_LOAD, OP_OP_IMM, OP_JALR, OP_SYSTEM: imm_fmt = FMT_I;
            OP_STORE:                               imm_fmt = FMT_S;
            OP_BRANCH:                              imm_fmt = FMT_B;
            OP_LUI, OP_AUIPC:                       imm_fmt = FMT_U;
            OP_JAL:                                 imm_fmt = FMT_J;
            default:                                imm_fmt = FMT_NONE;
        endcase
    end

    // Shift-immediates pass the raw I-field through, funct7 bits included.
    always_comb begin
        imm_next = '0;
        case (imm_fmt)
            FMT_I: imm_next = {{20{sign_bit}}, i_instr[31:20]};
            FMT_S: imm_next = {{20{sign_bit}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: imm_next = {{19{sign_bit}}, i_instr[31], i_instr[7],
                               i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U: imm_next = {i_instr[31:12], 12'b0};
            FMT_J: imm_next = {{11{sign_bit}}, i_instr[31], i_instr[19:12],
                               i_instr[20], i_instr[30:21], 1'b0};
            default: imm_next = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_imm <= '0;
        end else if (i_en) begin
            o_imm <= imm_next;
        end
    end

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: directed cases, stall, async reset and random sweep.
// Expected immediates are queued at drive time and popped one edge later.
module tb_imm_gen;

    logic        i_clk;
    logic        i_rst;
    logic        i_en;
    logic [31:0] i_instr;
    logic [31:0] o_imm;

    logic [31:0] exp_q[$];
    logic [31:0] model_imm;
    int          compared;
    int          mismatched;

    imm_gen #(.XLEN(32)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_instr (i_instr),
        .o_imm   (o_imm)
    );

    always #5 i_clk = ~i_clk;

    // Reference written straight from the format equations.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic [31:0] r;
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                r = {{20{i[31]}}, i[31:20]};
            7'b0100011: r = {{20{i[31]}}, i[31:25], i[11:7]};
            7'b1100011: r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'b0110111, 7'b0010111: r = {i[31:12], 12'b0};
            7'b1101111: r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] expected);
        compared++;
        assert (o_imm === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, o_imm, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic en);
        @(negedge i_clk);
        i_instr = instr;
        i_en    = en;
        if (en) model_imm = ref_imm(instr);
        exp_q.push_back(model_imm);
    endtask

    task automatic checkOutput(input string tag);
        @(posedge i_clk);
        #1;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: observed=%h expected=<empty scoreboard>", tag, o_imm);
        end else begin
            checkValue(tag, exp_q.pop_front());
        end
    endtask

    logic [6:0] valid_ops [9];

    initial begin
        valid_ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011,
                      7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
        compared   = 0;
        mismatched = 0;
        model_imm  = 32'h0;
        i_clk      = 1'b0;
        i_rst      = 1'b1;
        i_en       = 1'b0;
        i_instr    = 32'h0;

        #12;
        checkValue("reset_idle", 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;

        applyStimulus(32'hFFF00093, 1'b1); checkOutput("addi_neg1");
        applyStimulus(32'h0020A423, 1'b1); checkOutput("sw_s_type");
        applyStimulus(32'hFE000EE3, 1'b1); checkOutput("beq_b_type");
        applyStimulus(32'h123450B7, 1'b1); checkOutput("lui_u_type");
        applyStimulus(32'h001000EF, 1'b1); checkOutput("jal_j_type");
        applyStimulus(32'h002081B3, 1'b1); checkOutput("add_no_imm");
        applyStimulus(32'h7FF0A083, 1'b1); checkOutput("lw_max_pos");
        applyStimulus(32'h4050D093, 1'b1); checkOutput("srai_raw_field");
        applyStimulus(32'h0000000F, 1'b1); checkOutput("fence_no_imm");

        // Stall: o_imm must hold while i_instr changes underneath.
        applyStimulus(32'hFFF00093, 1'b1); checkOutput("stall_load");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(32'h123450B7, 1'b0); checkOutput("stall_hold");
        end
        applyStimulus(32'h123450B7, 1'b1); checkOutput("stall_release");

        // Asynchronous reset between edges, then held across an edge.
        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        checkValue("async_reset", 32'h0);
        i_en      = 1'b1;
        i_instr   = 32'hFFF00093;
        model_imm = 32'h0;
        @(posedge i_clk);
        #1;
        checkValue("reset_wins_edge", 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        applyStimulus(32'hFFF00093, 1'b1); checkOutput("post_reset_load");

        for (int n = 0; n < 1200; n++) begin
            logic [31:0] rnd;
            rnd      = $urandom;
            rnd[6:0] = valid_ops[$urandom_range(0, 8)];
            applyStimulus(rnd, 1'b1);
            checkOutput("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
